la_vjtag_dr_engine: RTL and testbench
=====================================

// Module: la_vjtag_dr_engine
// PURPOSE
//  User-side data-register engine behind the virtual JTAG hub node. It consumes the hub's tdi,
//  ir_in and virtual-state strobes and drives tdo/ir_out. It implements two DRs: CTRL
//  (status read / control write) and READ (streaming readout of the sample buffer).
//  Sits between the virtual JTAG node and the logic-analyser capture core/sample RAM, all in the tck domain.
// PARAMETERS
//  DATA_W   32   width of status, control and sample words (>=8)
//  ADDR_W   10   sample RAM address width; depth 2**ADDR_W
// PORTS
//  tck                 in   1       JTAG clock from hub; sole clock of the block
//  rst                 in   1       synchronous, active-high reset
//  tdi                 in   1       serial data from hub
//  tdo                 out  1       serial data to hub
//  ir_in               in   1       virtual IR: 0=CTRL, 1=READ
//  ir_out              out  1       virtual IR capture value (buffer-ready flag)
//  virtual_state_cdr   in   1       capture-DR strobe for this node
//  virtual_state_sdr   in   1       shift-DR strobe
//  virtual_state_udr   in   1       update-DR strobe
//  virtual_state_uir   in   1       update-IR strobe
//  status              in   DATA_W  capture-core status; bit0 = buffer ready
//  ctrl                out  DATA_W  control word to capture core
//  ctrl_wr             out  1       one-cycle pulse when ctrl is updated
//  mem_addr            out  ADDR_W  sample RAM read address (registered)
//  mem_rdata           in   DATA_W  sample RAM data; synchronous read, valid 1 tck after mem_addr
// BEHAVIOUR
//  - Reset: tdo=0, ir_out=0, ctrl=0, ctrl_wr=0, mem_addr=0, shift reg sr=0, bit count cnt=0.
//    A reset during a shift abandons it. The host must issue a new CDR.
//  - Strobes are mutually exclusive. If several are asserted, priority is cdr > sdr > udr > uir.
//  - tdo = sr[0] (combinational from the register). Shifting is LSB first: sr <= {tdi, sr[DATA_W-1:1]}.
//  - ir_out <= status[0] on every tck.
//  - ctrl_wr defaults to 0 each cycle.
//  - CTRL mode (ir_in=0):
//    CDR: sr <= status.
//    SDR: shift.
//    UDR: ctrl <= sr, ctrl_wr=1 for exactly one cycle.
//  - READ mode (ir_in=1), streaming:
//    UIR with ir_in=1: mem_addr <= 0, cnt <= 0.
//    CDR: sr <= mem_rdata, mem_addr <= mem_addr+1, cnt <= 0.
//    SDR with cnt<DATA_W-1: shift, cnt++.
//    SDR with cnt==DATA_W-1: sr <= mem_rdata (next word), mem_addr++, cnt <= 0.
//    The prefetched word is ready because DATA_W>=2 cycles separate reloads.
//    mem_addr wraps from 2**ADDR_W-1 to 0 silently.
//    UDR: no effect unless the optional feature is enabled.
//  - Strobes in the other mode never touch mem_addr or ctrl.
// CONFIGURATION
//  LA_VJTAG_ADDR_LOAD_EN defined: adds addr_sr[ADDR_W-1:0].
//    On every READ-mode SDR: addr_sr <= {tdi, addr_sr[ADDR_W-1:1]}.
//    READ-mode UDR: mem_addr <= addr_sr, giving random-access readout. The host shifts exactly ADDR_W bits.
//  Not defined: no addr_sr; READ-mode UDR is ignored; readout always starts at 0 after UIR.
// STRUCTURE
//  Package la_vjtag_pkg:
//    typedef enum logic [0:0] {IR_CTRL=1'b0, IR_READ=1'b1} vir_e;
//    localparam STATUS_READY_BIT=0.
//  Single module, no sub-modules. Shift/count logic is small enough to stay flat.
// TESTING
//  1 Reset mid-shift in READ mode -> next cycle all outputs 0.
//    A following CDR restarts from the current mem_addr.
//  2 IR=0, status=32'hA5A5_0001, CDR then 32 SDR -> tdo stream is LSB first, 1,0,0,0,...
//    ir_out=1.
//  3 IR=0, shift in 32'h0000_00F3, UDR -> ctrl=32'hF3, ctrl_wr high for exactly one tck.
//  4 UIR(IR=1), RAM[i]=i*3, CDR then 96 SDR -> tdo yields words 0,3,6.
//    mem_addr=3 at end.
//  5 mem_addr=2**ADDR_W-1, CDR + 32 SDR -> second word read is RAM[0] (wrap).
//  6 LA_VJTAG_ADDR_LOAD_EN: shift 10'd512, UDR, CDR -> first word out is RAM[512].
//    Without macro -> first word is RAM[0].

Source files
------------

// File: rtl/la_vjtag_pkg.sv
// ---------------------------------------------------------------------------
// la_vjtag_pkg
// Shared types and constants for the logic-analyser virtual JTAG DR engine.
//   vir_e             : virtual IR encoding (CTRL / READ data register select)
//   STATUS_READY_BIT  : bit of the capture-core status word flagging a full buffer
// ---------------------------------------------------------------------------
package la_vjtag_pkg;

  typedef enum logic [0:0] {
    IR_CTRL = 1'b0,
    IR_READ = 1'b1
  } vir_e;

  localparam int STATUS_READY_BIT = 0;

endpackage

// File: rtl/la_vjtag_dr_engine.sv
// ---------------------------------------------------------------------------
// la_vjtag_dr_engine
// User-side data-register engine behind a virtual JTAG hub node. Implements
// two DRs selected by the virtual IR:
//   CTRL : capture status word, shift, update writes the control word
//   READ : streaming readout of the sample RAM, one word per DATA_W shifts,
//          with the next word prefetched from a synchronous-read RAM
// Everything runs in the tck domain with a synchronous active-high reset.
//
// Optional feature (compile-time macro LA_VJTAG_ADDR_LOAD_EN):
//   adds an ADDR_W-bit address shift register loaded on READ-mode SDR; a
//   READ-mode UDR then moves mem_addr to the shifted address (random access).
//   Without the macro READ-mode UDR is ignored and readout starts at 0.
//
// Ports
//   tck, rst             clock and synchronous active-high reset
//   tdi / tdo            serial data from / to the hub (tdo = sr[0], LSB first)
//   ir_in / ir_out       virtual IR select / captured buffer-ready flag
//   virtual_state_cdr    capture-DR strobe   (priority cdr > sdr > udr > uir)
//   virtual_state_sdr    shift-DR strobe
//   virtual_state_udr    update-DR strobe
//   virtual_state_uir    update-IR strobe
//   status               capture-core status, bit0 = buffer ready
//   ctrl / ctrl_wr       control word and its one-cycle write pulse
//   mem_addr / mem_rdata sample RAM read port (data valid 1 tck after address)
// ---------------------------------------------------------------------------
module la_vjtag_dr_engine
  import la_vjtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  output logic              tdo,
  input  logic              ir_in,
  output logic              ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_uir,
  input  logic [DATA_W-1:0] status,
  output logic [DATA_W-1:0] ctrl,
  output logic              ctrl_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  vir_e             mode;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
`ifdef LA_VJTAG_ADDR_LOAD_EN
  logic [ADDR_W-1:0] addr_sr;
`endif

  assign mode = vir_e'(ir_in);
  assign tdo  = sr[0];

  // NOTE: all state lives in one clocked block with non-blocking updates, so
  // every register sees pre-edge values and the strobe priority is a single
  // if/else chain; the reset branch is synchronous because tck is the only clock.
  always_ff @(posedge tck) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      ir_out   <= 1'b0;
      ctrl     <= '0;
      ctrl_wr  <= 1'b0;
      mem_addr <= '0;
`ifdef LA_VJTAG_ADDR_LOAD_EN
      addr_sr  <= '0;
`endif
    end else begin
      ctrl_wr <= 1'b0;
      ir_out  <= status[STATUS_READY_BIT];

      if (virtual_state_cdr) begin
        if (mode == IR_READ) begin
          // mem_rdata already holds the word at mem_addr; advance to prefetch the next
          sr       <= mem_rdata;
          mem_addr <= mem_addr + 1'b1;
          cnt      <= '0;
        end else begin
          sr <= status;
        end
      end else if (virtual_state_sdr) begin
        if (mode == IR_READ) begin
          if (cnt == CNT_LAST) begin
            // Last bit of the word has been presented; swap in the prefetched word
            sr       <= mem_rdata;
            mem_addr <= mem_addr + 1'b1;
            cnt      <= '0;
          end else begin
            sr  <= {tdi, sr[DATA_W-1:1]};
            cnt <= cnt + 1'b1;
          end
`ifdef LA_VJTAG_ADDR_LOAD_EN
          addr_sr <= {tdi, addr_sr[ADDR_W-1:1]};
`endif
        end else begin
          sr <= {tdi, sr[DATA_W-1:1]};
        end
      end else if (virtual_state_udr) begin
        if (mode == IR_CTRL) begin
          ctrl    <= sr;
          ctrl_wr <= 1'b1;
        end
`ifdef LA_VJTAG_ADDR_LOAD_EN
        else begin
          mem_addr <= addr_sr;
        end
`endif
      end else if (virtual_state_uir) begin
        if (mode == IR_READ) begin
          mem_addr <= '0;
          cnt      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_la_vjtag_dr_engine.sv
// ---------------------------------------------------------------------------
// tb_la_vjtag_dr_engine
// Self-checking bench for la_vjtag_dr_engine. The sample RAM is a bench-owned
// array with a synchronous read port; expected words come straight from that
// array (stream order: word at start address, then consecutive addresses,
// each LSB first) and from the status/control values the bench chose.
// Honours LA_VJTAG_ADDR_LOAD_EN for the random-access readout expectations.
// ---------------------------------------------------------------------------
module tb_la_vjtag_dr_engine;
  import la_vjtag_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              tck = 1'b0;
  logic              rst;
  logic              tdi;
  logic              tdo;
  logic              ir_in;
  logic              ir_out;
  logic              virtual_state_cdr;
  logic              virtual_state_sdr;
  logic              virtual_state_udr;
  logic              virtual_state_uir;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] ctrl;
  logic              ctrl_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tck = ~tck;

  always @(posedge tck) mem_rdata <= ram[mem_addr];

  la_vjtag_dr_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .tck               (tck),
    .rst               (rst),
    .tdi               (tdi),
    .tdo               (tdo),
    .ir_in             (ir_in),
    .ir_out            (ir_out),
    .virtual_state_cdr (virtual_state_cdr),
    .virtual_state_sdr (virtual_state_sdr),
    .virtual_state_udr (virtual_state_udr),
    .virtual_state_uir (virtual_state_uir),
    .status            (status),
    .ctrl              (ctrl),
    .ctrl_wr           (ctrl_wr),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata)
  );

  // One tck with the given strobes; outputs are stable on return (#1 after the edge).
  task automatic tick(input logic c, input logic s, input logic u, input logic i, input logic d);
    virtual_state_cdr = c;
    virtual_state_sdr = s;
    virtual_state_udr = u;
    virtual_state_uir = i;
    tdi               = d;
    @(posedge tck);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Shifts DATA_W times and records tdo as presented before each shift.
  task automatic read_word(output logic [DATA_W-1:0] w);
    w = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w[b] = tdo;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic shift_in_word(input logic [DATA_W-1:0] v);
    for (int b = 0; b < DATA_W; b++) tick(1'b0, 1'b1, 1'b0, 1'b0, v[b]);
  endtask

  task automatic fill_ram_random();
    for (int a = 0; a < DEPTH; a++) ram[a] = $urandom;
  endtask

  task automatic test_reset();
    status = $urandom | 32'h1;
    ir_in  = IR_READ;
    rst    = 1'b1;
    idle(2);
    n_checks++;
    if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    n_checks++;
    if (ir_out !== 1'b0) begin n_fail++; $display("FAIL reset_ir_out: got %b expected 0", ir_out); end
    n_checks++;
    if (ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
    n_checks++;
    if (ctrl_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_wr: got %b expected 0", ctrl_wr); end
    n_checks++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    rst = 1'b0;
    idle(1);
    n_checks++;
    if (ir_out !== 1'b1) begin n_fail++; $display("FAIL ir_out_follow: got %b expected 1", ir_out); end
  endtask

  task automatic test_ctrl_read();
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] st_list [4];
    logic [ADDR_W-1:0] addr_before;
    st_list[0] = 32'hA5A5_0001;
    for (int k = 1; k < 4; k++) st_list[k] = $urandom;
    ir_in = IR_CTRL;
    addr_before = mem_addr;
    for (int k = 0; k < 4; k++) begin
      status = st_list[k];
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (ir_out !== status[0]) begin
        n_fail++; $display("FAIL ctrl_ir_out[%0d]: got %b expected %b", k, ir_out, status[0]);
      end
      read_word(w);
      n_checks++;
      if (w !== st_list[k]) begin
        n_fail++; $display("FAIL ctrl_status_stream[%0d]: got %h expected %h", k, w, st_list[k]);
      end
    end
    n_checks++;
    if (mem_addr !== addr_before) begin
      n_fail++; $display("FAIL ctrl_mode_mem_addr: got %h expected %h", mem_addr, addr_before);
    end
  endtask

  task automatic test_ctrl_write();
    logic [DATA_W-1:0] v;
    ir_in = IR_CTRL;
    for (int k = 0; k < 3; k++) begin
      v = (k == 0) ? 32'h0000_00F3 : DATA_W'($urandom);
      shift_in_word(v);
      n_checks++;
      if (ctrl_wr !== 1'b0) begin n_fail++; $display("FAIL ctrl_wr_early[%0d]: got %b expected 0", k, ctrl_wr); end
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (ctrl !== v) begin n_fail++; $display("FAIL ctrl_value[%0d]: got %h expected %h", k, ctrl, v); end
      n_checks++;
      if (ctrl_wr !== 1'b1) begin n_fail++; $display("FAIL ctrl_wr_pulse[%0d]: got %b expected 1", k, ctrl_wr); end
      idle(1);
      n_checks++;
      if (ctrl_wr !== 1'b0) begin n_fail++; $display("FAIL ctrl_wr_width[%0d]: got %b expected 0", k, ctrl_wr); end
      n_checks++;
      if (ctrl !== v) begin n_fail++; $display("FAIL ctrl_hold[%0d]: got %h expected %h", k, ctrl, v); end
    end
  endtask

  task automatic test_priority();
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] ctrl_before;
    logic              d;
    ir_in = IR_CTRL;
    v = $urandom;
    status = $urandom;
    status[0] = ~v[1];
    shift_in_word(v);
    ctrl_before = ctrl;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (tdo !== status[0]) begin n_fail++; $display("FAIL prio_cdr_tdo: got %b expected %b", tdo, status[0]); end
    n_checks++;
    if (ctrl_wr !== 1'b0) begin n_fail++; $display("FAIL prio_cdr_ctrl_wr: got %b expected 0", ctrl_wr); end
    d = 1'($urandom);
    tick(1'b0, 1'b1, 1'b1, 1'b0, d);
    n_checks++;
    if (tdo !== status[1] || ctrl_wr !== 1'b0 || ctrl !== ctrl_before) begin
      n_fail++; $display("FAIL prio_sdr: got tdo=%b wr=%b ctrl=%h expected tdo=%b wr=0 ctrl=%h",
                         tdo, ctrl_wr, ctrl, status[1], ctrl_before);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ctrl !== {d, status[DATA_W-1:1]} || ctrl_wr !== 1'b1) begin
      n_fail++; $display("FAIL prio_udr: got ctrl=%h wr=%b expected ctrl=%h wr=1",
                         ctrl, ctrl_wr, {d, status[DATA_W-1:1]});
    end
  endtask

  task automatic test_read_stream();
    logic [DATA_W-1:0] words [3];
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] ctrl_before;
    int                nw;
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'(a * 3);
    ir_in = IR_READ;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL uir_mem_addr: got %h expected 0", mem_addr); end
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (mem_addr !== ADDR_W'(1)) begin n_fail++; $display("FAIL cdr_mem_addr: got %h expected 1", mem_addr); end
    for (int k = 0; k < 3 * DATA_W; k++) begin
      if (k == 3 * DATA_W - 1) begin
        n_checks++;
        if (mem_addr !== ADDR_W'(3)) begin
          n_fail++; $display("FAIL stream_mem_addr_end: got %0d expected 3", mem_addr);
        end
      end
      words[k / DATA_W][k % DATA_W] = tdo;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
    end
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (words[j] !== DATA_W'(j * 3)) begin
        n_fail++; $display("FAIL stream_word[%0d]: got %h expected %h", j, words[j], DATA_W'(j * 3));
      end
    end

    fill_ram_random();
    ctrl_before = ctrl;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nw = $urandom_range(2, 5);
    for (int j = 0; j < nw; j++) begin
      read_word(w);
      n_checks++;
      if (w !== ram[j]) begin n_fail++; $display("FAIL rand_stream[%0d]: got %h expected %h", j, w, ram[j]); end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== ctrl_before || ctrl_wr !== 1'b0) begin
      n_fail++; $display("FAIL read_udr_ctrl: got ctrl=%h wr=%b expected ctrl=%h wr=0", ctrl, ctrl_wr, ctrl_before);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [DATA_W-1:0] w;
    fill_ram_random();
    status = $urandom | 32'h1;
    ir_in = IR_READ;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom));
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({tdo, ir_out, ctrl_wr} !== 3'b000 || ctrl !== '0 || mem_addr !== '0) begin
      n_fail++; $display("FAIL mid_shift_reset: got tdo=%b ir_out=%b wr=%b ctrl=%h addr=%h expected all 0",
                         tdo, ir_out, ctrl_wr, ctrl, mem_addr);
    end
    rst = 1'b0;
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (mem_addr !== ADDR_W'(1)) begin n_fail++; $display("FAIL restart_mem_addr: got %h expected 1", mem_addr); end
    read_word(w);
    n_checks++;
    if (w !== ram[0]) begin n_fail++; $display("FAIL restart_word: got %h expected %h", w, ram[0]); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] w1;
    fill_ram_random();
    ir_in = IR_READ;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (DEPTH - 1) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (mem_addr !== ADDR_W'(DEPTH - 1)) begin
      n_fail++; $display("FAIL wrap_pre_addr: got %0d expected %0d", mem_addr, DEPTH - 1);
    end
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL wrap_addr: got %0d expected 0", mem_addr); end
    read_word(w0);
    read_word(w1);
    n_checks++;
    if (w0 !== ram[DEPTH-1]) begin n_fail++; $display("FAIL wrap_word0: got %h expected %h", w0, ram[DEPTH-1]); end
    n_checks++;
    if (w1 !== ram[0]) begin n_fail++; $display("FAIL wrap_word1: got %h expected %h", w1, ram[0]); end
  endtask

  task automatic test_addr_load();
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] w;
    fill_ram_random();
    ir_in = IR_READ;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? ADDR_W'(512) : ADDR_W'($urandom);
`ifdef LA_VJTAG_ADDR_LOAD_EN
      exp_addr = a;
`else
      exp_addr = '0;
`endif
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int b = 0; b < ADDR_W; b++) tick(1'b0, 1'b1, 1'b0, 1'b0, a[b]);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      read_word(w);
      n_checks++;
      if (w !== ram[exp_addr]) begin
        n_fail++; $display("FAIL addr_load[%0d]: got %h expected %h (addr %0d)", k, w, ram[exp_addr], exp_addr);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    tdi               = 1'b0;
    ir_in             = IR_CTRL;
    virtual_state_cdr = 1'b0;
    virtual_state_sdr = 1'b0;
    virtual_state_udr = 1'b0;
    virtual_state_uir = 1'b0;
    status            = '0;
    fill_ram_random();

    test_reset();
    test_ctrl_read();
    test_ctrl_write();
    test_priority();
    test_read_stream();
    test_reset_mid_shift();
    test_wrap();
    test_addr_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
